// File: rtl/fifo_drain_sched.sv
// Read-domain scheduler: drains NUM_Q first-word-fall-through FIFO read ports, one
// round-robin grant of up to BURST words at a time, into a registered valid/ready stream.
// Define PRIO_Q0_EN to let queue 0 win every grant boundary at which it is non-empty.

module fifo_drain_sched_port #(
    parameter int DATA_W = 8
) (
    input  logic              sel,
    input  logic              pop,
    input  logic [DATA_W-1:0] rdata,
    output logic              r_en,
    output logic [DATA_W-1:0] rdata_m
);
    assign r_en    = sel & pop;
    assign rdata_m = sel ? rdata : '0;
endmodule

module fifo_drain_sched #(
    parameter int NUM_Q  = 4,
    parameter int DATA_W = 8,
    parameter int BURST  = 4,
    parameter int QID_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_Q-1:0]        q_empty,
    input  logic [NUM_Q*DATA_W-1:0] q_rdata,
    output logic [NUM_Q-1:0]        q_r_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [QID_W-1:0]        out_qid,
    output logic                    out_last,
    output logic                    busy
);
    localparam int               CNT_W    = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

    typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

    state_t                       state_q, state_d;
    logic [QID_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic [QID_W-1:0]             grant_q, grant_d;
    logic [CNT_W-1:0]             burst_cnt_q, burst_cnt_d;
    logic                         out_valid_q, out_valid_d;
    logic [DATA_W-1:0]            out_data_q, out_data_d;
    logic [QID_W-1:0]             out_qid_q, out_qid_d;
    logic                         out_last_q, out_last_d;

    logic                         load, pop, drained, burst_end, grant_done, adv_ptr;
    logic                         win_found;
    logic [QID_W-1:0]             win_idx, grant_nxt;
    logic [NUM_Q-1:0][DATA_W-1:0] rdata_m;
    logic [DATA_W-1:0]            sel_data;

    assign load = !out_valid_q || out_ready;

    // Winner search: first the queues at or above rr_ptr, then the ones below it.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int j = 0; j < NUM_Q; j++) begin
            if (!win_found && !q_empty[j] && QID_W'(j) >= rr_ptr_q) begin
                win_found = 1'b1;
                win_idx   = QID_W'(j);
            end
        end
        for (int j = 0; j < NUM_Q; j++) begin
            if (!win_found && !q_empty[j] && QID_W'(j) < rr_ptr_q) begin
                win_found = 1'b1;
                win_idx   = QID_W'(j);
            end
        end
`ifdef PRIO_Q0_EN
        if (!q_empty[0]) begin
            win_found = 1'b1;
            win_idx   = '0;
        end
`endif
    end

`ifdef PRIO_Q0_EN
    assign adv_ptr = (grant_q != '0);
`else
    assign adv_ptr = 1'b1;
`endif

    assign grant_nxt = (grant_q == QID_W'(NUM_Q - 1)) ? '0 : grant_q + 1'b1;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found) state_d = SERVE;
            SERVE:   if (grant_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs. Pops are masked by reset so nothing leaves a FIFO in a reset cycle.
    always_comb begin
        busy       = (state_q == SERVE);
        pop        = busy && load && !q_empty[grant_q] && !reset;
        drained    = busy && load && q_empty[grant_q];
        burst_end  = pop && (burst_cnt_q == CNT_LAST);
        grant_done = burst_end || drained;
    end

    for (genvar i = 0; i < NUM_Q; i++) begin : g_port
        fifo_drain_sched_port #(.DATA_W(DATA_W)) u_port (
            .sel     (grant_q == QID_W'(i)),
            .pop     (pop),
            .rdata   (q_rdata[i*DATA_W +: DATA_W]),
            .r_en    (q_r_en[i]),
            .rdata_m (rdata_m[i])
        );
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_Q; i++) sel_data = sel_data | rdata_m[i];
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        burst_cnt_d = burst_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_qid_d   = out_qid_q;
        out_last_d  = out_last_q;

        if (state_q == IDLE && win_found) begin
            grant_d     = win_idx;
            burst_cnt_d = '0;
        end

        if (pop) begin
            burst_cnt_d = burst_end ? '0 : burst_cnt_q + 1'b1;
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_qid_d   = grant_q;
            out_last_d  = (burst_cnt_q == CNT_LAST);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (grant_done && adv_ptr) rr_ptr_d = grant_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            burst_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_qid_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_qid_q   <= out_qid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_qid   = out_qid_q;
    assign out_last  = out_last_q;
endmodule

// File: tb/tb_fifo_drain_sched.sv
// Bench for fifo_drain_sched: FIFOs modelled as queues, expected word order derived
// from the grant/burst rules, with per-cycle protocol checks on r_en and the output register.

module tb_fifo_drain_sched;
    localparam int NUM_Q  = 4;
    localparam int DATA_W = 8;
    localparam int BURST  = 4;
    localparam int QID_W  = 2;
    localparam int TMO    = 600;
`ifdef PRIO_Q0_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [QID_W-1:0]  q;
        logic              l;
    } word_t;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [NUM_Q-1:0]        q_empty = '1;
    logic [NUM_Q*DATA_W-1:0] q_rdata = '0;
    logic [NUM_Q-1:0]        q_r_en;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [DATA_W-1:0]       out_data;
    logic [QID_W-1:0]        out_qid;
    logic                    out_last;
    logic                    busy;

    always #5 clk = ~clk;

    fifo_drain_sched #(.NUM_Q(NUM_Q), .DATA_W(DATA_W), .BURST(BURST), .QID_W(QID_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .q_empty   (q_empty),
        .q_rdata   (q_rdata),
        .q_r_en    (q_r_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_qid   (out_qid),
        .out_last  (out_last),
        .busy      (busy)
    );

    int                n_chk = 0;
    int                n_fail = 0;
    logic [DATA_W-1:0] tbq [NUM_Q][$];
    word_t             exp_out[$];
    word_t             exp_pop[$];
    int                m_ptr = 0;
    int                pops [NUM_Q];
    logic [NUM_Q-1:0]  pend_en = '0;
    bit                rst_edge = 1'b0, have_prev = 1'b0, prev_last = 1'b0;
    bit                p_valid = 1'b0, p_ready = 1'b0, p_arb = 1'b0;
    int                prev_q = 0;
    logic [DATA_W-1:0] p_data = '0;
    logic [QID_W-1:0]  p_qid = '0;
    logic              p_last = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_q();
        for (int i = 0; i < NUM_Q; i++) begin
            q_empty[i] = (tbq[i].size() == 0);
            q_rdata[i*DATA_W +: DATA_W] = (tbq[i].size() != 0) ? tbq[i][0] : '0;
        end
    endtask

    task automatic load(input int q, input int n);
        for (int k = 0; k < n; k++) tbq[q].push_back(DATA_W'($urandom));
        drive_q();
    endtask

    // Expected order: winner = first non-empty from the pointer (queue 0 first when
    // prioritised), it yields min(len, BURST) words, then the pointer moves past it.
    task automatic plan();
        logic [DATA_W-1:0] mq [NUM_Q][$];
        int w, n;
        for (int i = 0; i < NUM_Q; i++) mq[i] = tbq[i];
        while (1) begin
            w = -1;
            if (PRIO && mq[0].size() > 0) w = 0;
            for (int k = 0; k < NUM_Q; k++)
                if (w < 0 && mq[(m_ptr + k) % NUM_Q].size() > 0) w = (m_ptr + k) % NUM_Q;
            if (w < 0) break;
            n = (mq[w].size() < BURST) ? mq[w].size() : BURST;
            for (int k = 0; k < n; k++) begin
                word_t x;
                x.d = mq[w].pop_front();
                x.q = QID_W'(w);
                x.l = (k == BURST - 1);
                exp_out.push_back(x);
                exp_pop.push_back(x);
            end
            if (!(PRIO && w == 0)) m_ptr = (w + 1) % NUM_Q;
        end
    endtask

    task automatic neg_chk();
        logic [NUM_Q-1:0] en;
        bit ld;
        int pq;
        @(negedge clk);
        en = q_r_en;
        ld = !out_valid || out_ready;
        chk("ren_onehot", 32'($onehot0(en)), 32'd1);
        chk("ren_on_empty", 32'(en & q_empty), 32'd0);
        if (reset) chk("ren_in_reset", 32'(en), 32'd0);
        if (rst_edge) begin
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        if (p_arb && !rst_edge) chk("arb_one_cycle", 32'(busy), 32'd1);
        if (have_prev && prev_last && !rst_edge) chk("burst_end_idle", 32'(busy), 32'd0);
        if (!reset && !rst_edge && p_valid && !p_ready) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(p_data));
            chk("stall_qid", 32'(out_qid), 32'(p_qid));
            chk("stall_last", 32'(out_last), 32'(p_last));
        end
        if (!busy) begin
            chk("ren_idle", 32'(en), 32'd0);
            have_prev = 1'b0;
        end else if (!ld) begin
            chk("ren_stall", 32'(en), 32'd0);
        end else if (!reset) begin
            if (!have_prev) chk("first_pop", 32'(en != 0), 32'd1);
            else if (!prev_last && tbq[prev_q].size() > 0)
                chk("burst_rate", 32'(en), 32'd1 << prev_q);
        end
        if (en != 0) begin
            pq = 0;
            for (int i = 0; i < NUM_Q; i++) if (en[i]) pq = i;
            chk("pop_expected", 32'(exp_pop.size() > 0), 32'd1);
            if (exp_pop.size() > 0) begin
                chk("pop_qid", 32'(pq), 32'(exp_pop[0].q));
                prev_last = exp_pop[0].l;
                void'(exp_pop.pop_front());
            end
            have_prev = 1'b1;
            prev_q = pq;
        end
        if (!reset && out_valid && out_ready) begin
            chk("out_expected", 32'(exp_out.size() > 0), 32'd1);
            if (exp_out.size() > 0) begin
                chk("out_data", 32'(out_data), 32'(exp_out[0].d));
                chk("out_qid", 32'(out_qid), 32'(exp_out[0].q));
                chk("out_last", 32'(out_last), 32'(exp_out[0].l));
                void'(exp_out.pop_front());
            end
        end
        p_arb   = !busy && !reset && (q_empty != '1);
        p_valid = out_valid;
        p_ready = out_ready;
        p_data  = out_data;
        p_qid   = out_qid;
        p_last  = out_last;
        pend_en = en;
    endtask

    task automatic pos_apply();
        @(posedge clk);
        rst_edge = reset;
        #1;
        for (int i = 0; i < NUM_Q; i++)
            if (pend_en[i] && tbq[i].size() > 0) begin
                void'(tbq[i].pop_front());
                pops[i]++;
            end
        pend_en = '0;
        if (rst_edge) begin
            exp_out.delete();
            exp_pop.delete();
            m_ptr = 0;
            have_prev = 1'b0;
            plan();
        end
        drive_q();
    endtask

    task automatic cyc();
        neg_chk();
        pos_apply();
    endtask

    task automatic drain(input bit rnd);
        int t = 0;
        while ((exp_out.size() != 0 || busy || out_valid) && t < TMO) begin
            out_ready = rnd ? 1'($urandom) : 1'b1;
            cyc();
            t++;
        end
        chk("drain_in_time", 32'(t < TMO), 32'd1);
        chk("drain_exp_out", 32'(exp_out.size()), 32'd0);
        chk("drain_exp_pop", 32'(exp_pop.size()), 32'd0);
        for (int i = 0; i < NUM_Q; i++) chk("drain_fifo_empty", 32'(tbq[i].size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, base;
        for (int i = 0; i < NUM_Q; i++) pops[i] = 0;

        // Full queues held in reset for 3 cycles, then release.
        for (int i = 0; i < NUM_Q; i++) load(i, 6);
        pos_apply();
        repeat (3) cyc();
        reset = 1'b0;
        out_ready = 1'b1;
        neg_chk();
        chk("rel_c1_ren", 32'(q_r_en), 32'd0);
        chk("rel_c1_busy", 32'(busy), 32'd0);
        pos_apply();
        neg_chk();
        chk("rel_c2_ren", 32'(q_r_en), 32'd1);
        chk("rel_c2_busy", 32'(busy), 32'd1);
        pos_apply();
        drain(1'b0);

        // Lone short queue drains early, then pointer position decides the next winner.
        load(2, 2);
        plan();
        drain(1'b0);
        load(0, 3);
        load(3, 3);
        plan();
        drain(1'b0);

        // Stall the first word for 5 cycles.
        load(1, 6);
        plan();
        out_ready = 1'b1;
        t = 0;
        while (!out_valid && t < 20) begin
            cyc();
            t++;
        end
        chk("stall_first_word", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        repeat (5) cyc();
        drain(1'b0);

        // Queues 0 and 1 together.
        load(0, 6);
        load(1, 6);
        plan();
        drain(1'b0);

        // Random fills with random backpressure.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NUM_Q; i++) load(i, int'($urandom_range(0, 9)));
            plan();
            drain(1'b1);
        end

        // Reset in the middle of a burst, with the pointer moved off zero first.
        load(2, 1);
        plan();
        drain(1'b0);
        load(3, 8);
        plan();
        out_ready = 1'b1;
        base = pops[3];
        t = 0;
        while (pops[3] - base < 2 && t < 40) begin
            cyc();
            t++;
        end
        chk("mid_burst_reached", 32'(pops[3] - base), 32'd2);
        reset = 1'b1;
        out_ready = 1'b0;
        cyc();
        load(0, 2);
        cyc();
        reset = 1'b0;
        drain(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
